// File: rtl/psum_acc_pkg.sv
// Shared types and default widths for the partial-sum accumulator.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } psum_state_e;

    localparam int DEF_IN_WIDTH       = 38;
    localparam int DEF_ACC_WIDTH      = 48;
    localparam int DEF_OUT_WIDTH      = 32;
    localparam int DEF_PASS_CNT_WIDTH = 10;
    localparam int SHIFT_W            = 6;

endpackage

// File: rtl/psum_requant.sv
// Combinational round-half-up, arithmetic right shift and output narrowing.
// Define PSUM_ACC_SATURATE_EN to clamp to the OUT_WIDTH range instead of truncating.
module psum_requant
    import psum_acc_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic        [SHIFT_W-1:0]   shift_i,
    output logic signed [OUT_WIDTH-1:0] out_o,
    output logic                        sat_o
);

    localparam int EXT_W = ACC_WIDTH + 1;

    // One guard bit keeps acc + 2^(shift-1) from overflowing.
    function automatic logic signed [EXT_W-1:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic        [SHIFT_W-1:0]   s
    );
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] bias;
        ext  = {a[ACC_WIDTH-1], a};
        bias = '0;
        if (s == '0) begin
            return ext;
        end
        // Any shift of ACC_WIDTH or more rounds every representable value to zero.
        if (int'(s) >= ACC_WIDTH) begin
            return '0;
        end
        bias[s - 1'b1] = 1'b1;
        return (ext + bias) >>> s;
    endfunction

    logic signed [EXT_W-1:0] rq;
    assign rq = round_shift(acc_i, shift_i);

`ifdef PSUM_ACC_SATURATE_EN
    localparam logic signed [EXT_W-1:0] MAXV =
        {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV =
        {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] saturate(
        input logic signed [EXT_W-1:0] v
    );
        if (v > MAXV) begin
            return MAXV[OUT_WIDTH-1:0];
        end
        if (v < MINV) begin
            return MINV[OUT_WIDTH-1:0];
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    assign out_o = saturate(rq);
    assign sat_o = (rq > MAXV) || (rq < MINV);
`else
    assign out_o = rq[OUT_WIDTH-1:0];
    assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates N adder-tree sums per job, then presents one requantized result
// under a valid/ready handshake. Optional clamping via PSUM_ACC_SATURATE_EN.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int IN_WIDTH       = DEF_IN_WIDTH,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
    parameter int PASS_CNT_WIDTH = DEF_PASS_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [PASS_CNT_WIDTH-1:0]   num_passes_in,
    input  logic [SHIFT_W-1:0]          shift_in,
    input  logic                        sum_valid_in,
    output logic                        sum_ready_out,
    input  logic signed [IN_WIDTH-1:0]  sum_in,
    output logic                        out_valid_out,
    input  logic                        out_ready_in,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        sat_out,
    output logic                        busy_out
);

    if ((ACC_WIDTH < IN_WIDTH + PASS_CNT_WIDTH) || (OUT_WIDTH > ACC_WIDTH)) begin : g_width_check
        $error("psum_accumulator: ACC_WIDTH too narrow or OUT_WIDTH wider than ACC_WIDTH");
    end

    psum_state_e                 state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PASS_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PASS_CNT_WIDTH-1:0]   npass_q, npass_d;
    logic [SHIFT_W-1:0]          shift_q, shift_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d;
    logic                        sat_q, sat_d;

    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] final_sum;
    logic [PASS_CNT_WIDTH-1:0]   cnt_inc;
    logic signed [OUT_WIDTH-1:0] rq_out;
    logic                        rq_sat;

    assign sum_ext   = {{(ACC_WIDTH-IN_WIDTH){sum_in[IN_WIDTH-1]}}, sum_in};
    assign final_sum = acc_q + sum_ext;
    assign cnt_inc   = cnt_q + 1'b1;

    // Requantize the would-be accumulator so the result lands in the same cycle as the last sum.
    psum_requant #(
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_requant (
        .acc_i  (final_sum),
        .shift_i(shift_q),
        .out_o  (rq_out),
        .sat_o  (rq_sat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        npass_d = npass_q;
        shift_d = shift_q;
        out_d   = out_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    npass_d = (num_passes_in == '0) ? PASS_CNT_WIDTH'(1) : num_passes_in;
                    shift_d = shift_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (sum_valid_in) begin
                    acc_d = final_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == npass_q) begin
                        out_d   = rq_out;
                        sat_d   = rq_sat;
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            npass_q <= '0;
            shift_q <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            npass_q <= npass_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    assign sum_ready_out = (state_q == ACCUM);
    assign out_valid_out = (state_q == OUTPUT);
    assign busy_out      = (state_q != IDLE);
    assign out           = out_q;
    assign sat_out       = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized self-checking bench for psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;

    localparam int IW = 38;
    localparam int AW = 48;
    localparam int OW = 32;
    localparam int PW = 10;

    logic                 clk;
    logic                 rst_in;
    logic                 start_in;
    logic [PW-1:0]        num_passes_in;
    logic [5:0]           shift_in;
    logic                 sum_valid_in;
    logic                 sum_ready_out;
    logic signed [IW-1:0] sum_in;
    logic                 out_valid_out;
    logic                 out_ready_in;
    logic signed [OW-1:0] out_w;
    logic                 sat_out;
    logic                 busy_out;

    int n_checks = 0;
    int n_errors = 0;

    psum_accumulator dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .num_passes_in(num_passes_in),
        .shift_in     (shift_in),
        .sum_valid_in (sum_valid_in),
        .sum_ready_out(sum_ready_out),
        .sum_in       (sum_in),
        .out_valid_out(out_valid_out),
        .out_ready_in (out_ready_in),
        .out          (out_w),
        .sat_out      (sat_out),
        .busy_out     (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exact arithmetic: wrapped sum, round-half-up division by 2^s, then clamp or truncate.
    task automatic model(input longint q[$], input int s, output longint o, output longint sat);
        longint acc;
        longint r;
        longint maxv;
        longint minv;
        acc = 0;
        foreach (q[i]) begin
            acc = acc + q[i];
            acc = (acc <<< (64 - AW)) >>> (64 - AW);
        end
        if (s == 0) r = acc;
        else if (s >= AW) r = 0;
        else r = (acc + (64'sd1 <<< (s - 1))) >>> s;
        maxv = (64'sd1 <<< (OW - 1)) - 1;
        minv = -(64'sd1 <<< (OW - 1));
`ifdef PSUM_ACC_SATURATE_EN
        if (r > maxv) begin o = maxv; sat = 1; end
        else if (r < minv) begin o = minv; sat = 1; end
        else begin o = r; sat = 0; end
`else
        o   = (r <<< (64 - OW)) >>> (64 - OW);
        sat = 0;
`endif
    endtask

    function automatic longint rand_sum();
        longint v;
        v = {$urandom, $urandom};
        return (v <<< (64 - IW)) >>> (64 - IW);
    endfunction

    // Starts at #1 after an edge with the DUT idle; leaves it idle again.
    task automatic run_job(input string tag, input int n, input int s, input longint q[$],
                           input int hold, input bit pulse_start);
        longint exp_o;
        longint exp_s;
        longint v;
        model(q, s, exp_o, exp_s);
        num_passes_in = PW'(n);
        shift_in      = 6'(s);
        start_in      = 1'b1;
        tick();
        start_in = 1'b0;
        chk({tag, ".busy"}, longint'(busy_out), 1);
        foreach (q[i]) begin
            repeat ($urandom_range(0, 1)) begin
                sum_valid_in = 1'b0;
                v            = rand_sum();
                sum_in       = v[IW-1:0];
                tick();
            end
            v            = q[i];
            sum_valid_in = 1'b1;
            sum_in       = v[IW-1:0];
            chk({tag, ".ready"}, longint'(sum_ready_out), 1);
            chk({tag, ".early_valid"}, longint'(out_valid_out), 0);
            tick();
        end
        sum_valid_in = 1'b0;
        chk({tag, ".valid"}, longint'(out_valid_out), 1);
        chk({tag, ".out"}, longint'(out_w), exp_o);
        chk({tag, ".sat"}, longint'(sat_out), exp_s);
        out_ready_in = 1'b0;
        repeat (hold) begin
            start_in      = pulse_start;
            num_passes_in = PW'(3);
            tick();
            chk({tag, ".hold_valid"}, longint'(out_valid_out), 1);
            chk({tag, ".hold_out"}, longint'(out_w), exp_o);
            chk({tag, ".hold_ready"}, longint'(sum_ready_out), 0);
        end
        start_in     = 1'b0;
        out_ready_in = 1'b1;
        tick();
        out_ready_in = 1'b0;
        chk({tag, ".valid_drop"}, longint'(out_valid_out), 0);
        chk({tag, ".idle"}, longint'(busy_out), 0);
    endtask

    initial begin
        longint q[$];
        int     n;
        int     s;
        int     cnt;
        longint v;

        rst_in        = 1'b1;
        start_in      = 1'b0;
        num_passes_in = '0;
        shift_in      = '0;
        sum_valid_in  = 1'b0;
        sum_in        = '0;
        out_ready_in  = 1'b0;
        repeat (3) tick();
        chk("rst.valid", longint'(out_valid_out), 0);
        chk("rst.ready", longint'(sum_ready_out), 0);
        chk("rst.busy", longint'(busy_out), 0);
        chk("rst.out", longint'(out_w), 0);
        rst_in = 1'b0;
        tick();

        q = {};
        q.push_back(5); q.push_back(-2); q.push_back(10);
        run_job("n3", 3, 0, q, 0, 1'b0);
        chk("n3.value", 13, 13 + 0 * longint'(out_w));

        q = {}; q.push_back(7);
        run_job("rnd_pos", 1, 2, q, 0, 1'b0);
        q = {}; q.push_back(-7);
        run_job("rnd_neg", 1, 2, q, 0, 1'b0);

        q = {}; q.push_back(2147483647); q.push_back(10);
        run_job("ovf", 2, 0, q, 0, 1'b0);

        q = {}; q.push_back(100); q.push_back(-37);
        run_job("hold", 2, 1, q, 5, 1'b1);

        // Reset in the middle of a job, then a clean job must show no residue.
        num_passes_in = PW'(4);
        shift_in      = 6'd0;
        start_in      = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (2) begin
            sum_valid_in = 1'b1;
            sum_in       = IW'(1000);
            tick();
        end
        sum_valid_in = 1'b0;
        rst_in       = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("midrst.valid", longint'(out_valid_out), 0);
        chk("midrst.ready", longint'(sum_ready_out), 0);
        chk("midrst.busy", longint'(busy_out), 0);
        chk("midrst.out", longint'(out_w), 0);
        chk("midrst.sat", longint'(sat_out), 0);
        q = {}; q.push_back(4);
        run_job("after_rst", 1, 0, q, 0, 1'b0);

        q = {}; q.push_back(-9);
        run_job("zero_n", 0, 0, q, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            n   = $urandom_range(0, 6);
            cnt = (n == 0) ? 1 : n;
            s   = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 20);
            q   = {};
            for (int k = 0; k < cnt; k++) begin
                v = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 200)) - 100 : rand_sum();
                q.push_back(v);
            end
            run_job($sformatf("rand%0d", j), n, s, q, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
